clk_freq_checker: RTL and testbench

CLK_FREQ_CHECKER -- requirements
Module: clk_freq_checker

---
 rtl/clk_freq_checker.sv | 195 +++++++++++++++++++
 tb/tb_clk_freq_checker.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/clk_freq_checker.sv
// Multi-channel clock frequency checker.
// Each channel receives a slow toggle (a counter MSB) from a foreign clock domain.
// Rising edges of the synchronised toggle are counted over a fixed window of CLK
// cycles, and the count is compared against a per-channel [min, max] range.
// Windows run back to back for as long as EN is high and the PLL stays locked.

// Per-channel synchroniser, edge detector, saturating counter and range compare.
module clk_freq_checker_lane #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             tgl,
  input  logic             gate,
  input  logic [CNT_W-1:0] exp_min,
  input  logic [CNT_W-1:0] exp_max,
  output logic [CNT_W-1:0] cnt,
  output logic             in_range
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   tgl_d;
  logic                   rise;

  // Synchroniser chain plus one extra flop for rising-edge detection.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync  <= '0;
      tgl_d <= 1'b0;
    end else begin
      sync  <= {sync[SYNC_STAGES-2:0], tgl};
      tgl_d <= sync[SYNC_STAGES-1];
    end
  end

  assign rise = sync[SYNC_STAGES-1] & ~tgl_d;

  // Count only while gating.  Outside GATE the counter sits at zero, so every
  // window starts from a clean count and edges seen during EVAL are dropped.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)             cnt <= '0;
    else if (!gate)         cnt <= '0;
    else if (rise && (cnt != {CNT_W{1'b1}})) cnt <= cnt + 1'b1;
  end

  // When min > max, no count can satisfy both bounds, so the channel fails.
  assign in_range = (cnt >= exp_min) && (cnt <= exp_max);

endmodule

// Top level: lock synchroniser, window FSM and result registers.
module clk_freq_checker #(
  parameter int NCH           = 6,
  parameter int CNT_W         = 16,
  parameter int GATE_CYCLES   = 1048576,
  parameter int SETTLE_CYCLES = 256,
  parameter int SYNC_STAGES   = 2
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 EN,
  input  logic                 LOCKED,
  input  logic [NCH-1:0]       I_TOGGLE,
  input  logic [NCH*CNT_W-1:0] I_EXP_MIN,
  input  logic [NCH*CNT_W-1:0] I_EXP_MAX,
  output logic [NCH*CNT_W-1:0] O_CNT,
  output logic                 O_VALID,
  output logic [NCH-1:0]       O_PASS,
  output logic                 O_ALL_PASS,
  output logic                 O_LOCK_LOST
);

  localparam int GW = $clog2(GATE_CYCLES);
  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_GATE, S_EVAL} state_t;

  state_t                      state, state_nxt;
  logic [SYNC_STAGES-1:0]      lock_sync;
  logic                        lock_s;
  logic [SW-1:0]               settle_cnt;
  logic [GW-1:0]               gate_cnt;
  logic                        eval_ok;
  logic                        lost_evt;
  logic                        start_evt;

  logic [NCH-1:0][CNT_W-1:0]   min_a, max_a, cnt_a;
  logic [NCH-1:0]              pass_a;

  assign min_a = I_EXP_MIN;
  assign max_a = I_EXP_MAX;

  // One lane per monitored channel.
  for (genvar i = 0; i < NCH; i++) begin : g_lane
    clk_freq_checker_lane #(
      .CNT_W       (CNT_W),
      .SYNC_STAGES (SYNC_STAGES)
    ) u_lane (
      .CLK      (CLK),
      .RST_N    (RST_N),
      .tgl      (I_TOGGLE[i]),
      .gate     (state == S_GATE),
      .exp_min  (min_a[i]),
      .exp_max  (max_a[i]),
      .cnt      (cnt_a[i]),
      .in_range (pass_a[i])
    );
  end

  // LOCKED comes straight from the PLL, so resynchronise it before use.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) lock_sync <= '0;
    else        lock_sync <= {lock_sync[SYNC_STAGES-2:0], LOCKED};
  end

  assign lock_s = lock_sync[SYNC_STAGES-1];

  // FSM state register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.  A lock loss outranks EN going low, and both abort a
  // pending EVAL so no result is published from a broken window.
  always_comb begin
    state_nxt = state;
    eval_ok   = 1'b0;
    lost_evt  = 1'b0;
    start_evt = 1'b0;
    case (state)
      S_IDLE:   if (EN && lock_s) begin
                  state_nxt = S_SETTLE;
                  start_evt = 1'b1;
                end
      S_SETTLE: if (settle_cnt == '0) state_nxt = S_GATE;
      S_GATE:   if (gate_cnt == '0)   state_nxt = S_EVAL;
      S_EVAL:   begin
                  state_nxt = S_GATE;
                  eval_ok   = 1'b1;
                end
      default:  state_nxt = S_IDLE;
    endcase
    if ((state != S_IDLE) && !lock_s) begin
      state_nxt = S_IDLE;
      lost_evt  = 1'b1;
      eval_ok   = 1'b0;
    end else if (!EN) begin
      state_nxt = S_IDLE;
      eval_ok   = 1'b0;
      start_evt = 1'b0;
    end
  end

  // Settle and gate down-counters; each reloads while its phase is inactive so
  // SETTLE lasts SETTLE_CYCLES cycles and every GATE lasts GATE_CYCLES cycles.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      settle_cnt <= '0;
      gate_cnt   <= '0;
    end else begin
      if (state != S_SETTLE)    settle_cnt <= SW'(SETTLE_CYCLES - 1);
      else if (settle_cnt != '0) settle_cnt <= settle_cnt - 1'b1;
      if (state != S_GATE)      gate_cnt <= GW'(GATE_CYCLES - 1);
      else if (gate_cnt != '0)  gate_cnt <= gate_cnt - 1'b1;
    end
  end

  // Result registers: loaded at the end of EVAL, so O_VALID lines up with them.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      O_CNT       <= '0;
      O_VALID     <= 1'b0;
      O_PASS      <= '0;
      O_ALL_PASS  <= 1'b0;
      O_LOCK_LOST <= 1'b0;
    end else begin
      O_VALID <= eval_ok;
      if (eval_ok) begin
        O_CNT      <= cnt_a;
        O_PASS     <= pass_a;
        O_ALL_PASS <= &pass_a;
      end
      if (lost_evt) begin
        O_PASS      <= '0;
        O_ALL_PASS  <= 1'b0;
        O_LOCK_LOST <= 1'b1;
      end else if (start_evt) begin
        O_LOCK_LOST <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_clk_freq_checker.sv
// Directed bench for clk_freq_checker: a 2-channel instance with 64-cycle
// windows, plus a 1-channel, 4-bit instance that exercises counter saturation.
module tb_clk_freq_checker;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        locked = 1'b0;
  logic [1:0]  tog = 2'b00;
  logic [0:0]  tog_s = 1'b0;
  logic [31:0] exp_min = '0;
  logic [31:0] exp_max = '0;
  logic [31:0] o_cnt;
  logic        o_valid;
  logic [1:0]  o_pass;
  logic        o_all;
  logic        o_lost;
  logic [3:0]  s_min = 4'd0;
  logic [3:0]  s_max = 4'd15;
  logic [3:0]  s_cnt;
  logic        s_valid;
  logic [0:0]  s_pass;
  logic        s_all;
  logic        s_lost;

  int checks = 0;
  int errors = 0;
  int vcnt   = 0;
  int half0  = 4;
  int half1  = 8;

  clk_freq_checker #(
    .NCH(2), .CNT_W(16), .GATE_CYCLES(64), .SETTLE_CYCLES(4), .SYNC_STAGES(2)
  ) dut (
    .CLK(clk), .RST_N(rst_n), .EN(en), .LOCKED(locked), .I_TOGGLE(tog),
    .I_EXP_MIN(exp_min), .I_EXP_MAX(exp_max), .O_CNT(o_cnt), .O_VALID(o_valid),
    .O_PASS(o_pass), .O_ALL_PASS(o_all), .O_LOCK_LOST(o_lost)
  );

  clk_freq_checker #(
    .NCH(1), .CNT_W(4), .GATE_CYCLES(64), .SETTLE_CYCLES(4), .SYNC_STAGES(2)
  ) dut_sat (
    .CLK(clk), .RST_N(rst_n), .EN(en), .LOCKED(locked), .I_TOGGLE(tog_s),
    .I_EXP_MIN(s_min), .I_EXP_MAX(s_max), .O_CNT(s_cnt), .O_VALID(s_valid),
    .O_PASS(s_pass), .O_ALL_PASS(s_all), .O_LOCK_LOST(s_lost)
  );

  always #5 clk = ~clk;

  // Toggle sources: ch0 period 2*half0, ch1 period 2*half1 (held when half1==0),
  // saturation channel period 2.
  initial begin
    int p0 = 0;
    int p1 = 0;
    forever begin
      @(posedge clk);
      #1;
      tog_s = ~tog_s;
      p0++;
      if (p0 >= half0) begin p0 = 0; tog[0] = ~tog[0]; end
      if (half1 != 0) begin
        p1++;
        if (p1 >= half1) begin p1 = 0; tog[1] = ~tog[1]; end
      end
    end
  end

  always @(negedge clk) if (o_valid) vcnt++;

  task automatic wait_valid(input int n, output int cyc, output bit ok);
    ok = 1'b0; cyc = 0;
    while (!ok && cyc < n) begin
      @(negedge clk); cyc++; ok = o_valid;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (o_cnt !== 32'd0) begin errors++; $display("FAIL reset_cnt got %0h want 0", o_cnt); end
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", o_valid); end
    checks++; if (o_pass !== 2'b00) begin errors++; $display("FAIL reset_pass got %b want 00", o_pass); end
    checks++; if (o_all !== 1'b0) begin errors++; $display("FAIL reset_all got %b want 0", o_all); end
    checks++; if (o_lost !== 1'b0) begin errors++; $display("FAIL reset_lost got %b want 0", o_lost); end
    checks++; if (s_cnt !== 4'd0) begin errors++; $display("FAIL reset_sat_cnt got %0d want 0", s_cnt); end
    exp_min = {16'd3, 16'd7};
    exp_max = {16'd5, 16'd9};
    rst_n = 1'b1; en = 1'b1; locked = 1'b1;
  endtask

  task automatic test_basic();
    int cyc; bit ok;
    wait_valid(300, cyc, ok);
    checks++; if (!ok) begin errors++; $display("FAIL basic_first_valid timeout after %0d cycles", cyc); end
    checks++; if (o_cnt !== {16'd4, 16'd8}) begin errors++; $display("FAIL basic_cnt got %0h want 00040008", o_cnt); end
    checks++; if (o_pass !== 2'b11) begin errors++; $display("FAIL basic_pass got %b want 11", o_pass); end
    checks++; if (o_all !== 1'b1) begin errors++; $display("FAIL basic_all got %b want 1", o_all); end
    checks++; if (o_lost !== 1'b0) begin errors++; $display("FAIL basic_lost got %b want 0", o_lost); end
    @(negedge clk);
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL basic_pulse_width got %b want 0", o_valid); end
    wait_valid(200, cyc, ok);
    checks++; if (!ok || cyc != 64) begin errors++; $display("FAIL basic_period got %0d want 65", cyc + 1); end
    checks++; if (o_cnt !== {16'd4, 16'd8}) begin errors++; $display("FAIL basic_cnt2 got %0h want 00040008", o_cnt); end
  endtask

  task automatic test_idle_channel();
    int cyc; bit ok;
    half1 = 0;
    wait_valid(200, cyc, ok);
    wait_valid(200, cyc, ok);
    checks++; if (!ok) begin errors++; $display("FAIL idle_valid timeout"); end
    checks++; if (o_cnt !== {16'd0, 16'd8}) begin errors++; $display("FAIL idle_cnt got %0h want 00000008", o_cnt); end
    checks++; if (o_pass !== 2'b01) begin errors++; $display("FAIL idle_pass got %b want 01", o_pass); end
    checks++; if (o_all !== 1'b0) begin errors++; $display("FAIL idle_all got %b want 0", o_all); end
    half1 = 8;
    wait_valid(200, cyc, ok);
  endtask

  task automatic test_bounds();
    int cyc; bit ok;
    exp_min = {16'd4, 16'd8};
    exp_max = {16'd4, 16'd8};
    wait_valid(200, cyc, ok);
    checks++; if (o_pass !== 2'b11 || o_cnt !== {16'd4, 16'd8}) begin
      errors++; $display("FAIL bounds_exact got pass %b cnt %0h want 11 00040008", o_pass, o_cnt); end
    exp_min = {16'd0, 16'd9};
    exp_max = {16'd3, 16'd20};
    wait_valid(200, cyc, ok);
    checks++; if (o_pass !== 2'b00 || o_all !== 1'b0) begin
      errors++; $display("FAIL bounds_outside got pass %b all %b want 00 0", o_pass, o_all); end
    exp_min = {16'd3, 16'd7};
    exp_max = {16'd5, 16'd9};
    repeat (30) @(negedge clk);
    exp_min = {16'd3, 16'd9};
    repeat (20) @(negedge clk);
    exp_min = {16'd3, 16'd7};
    wait_valid(200, cyc, ok);
    checks++; if (o_pass !== 2'b11) begin errors++; $display("FAIL bounds_sample_eval got %b want 11", o_pass); end
  endtask

  task automatic test_lock_lost();
    int cyc; bit ok; int vbase;
    repeat (20) @(negedge clk);
    vbase = vcnt;
    locked = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (o_lost !== 1'b0) begin errors++; $display("FAIL lock_early got %b want 0", o_lost); end
    @(negedge clk);
    checks++; if (o_lost !== 1'b1) begin errors++; $display("FAIL lock_lost got %b want 1", o_lost); end
    checks++; if (o_pass !== 2'b00 || o_all !== 1'b0) begin
      errors++; $display("FAIL lock_pass got %b all %b want 00 0", o_pass, o_all); end
    checks++; if (o_cnt !== {16'd4, 16'd8}) begin errors++; $display("FAIL lock_cnt_hold got %0h want 00040008", o_cnt); end
    repeat (100) @(negedge clk);
    checks++; if (vcnt != vbase) begin errors++; $display("FAIL lock_no_valid got %0d pulses want 0", vcnt - vbase); end
    locked = 1'b1;
    @(negedge clk);
    checks++; if (o_lost !== 1'b1) begin errors++; $display("FAIL lock_sticky got %b want 1", o_lost); end
    repeat (2) @(negedge clk);
    checks++; if (o_lost !== 1'b0) begin errors++; $display("FAIL lock_clear got %b want 0", o_lost); end
    wait_valid(200, cyc, ok);
    checks++; if (!ok || o_pass !== 2'b11 || o_cnt !== {16'd4, 16'd8}) begin
      errors++; $display("FAIL lock_restart got ok %b pass %b cnt %0h want 1 11 00040008", ok, o_pass, o_cnt); end
  endtask

  task automatic test_enable();
    int cyc; bit ok; int vbase;
    repeat (20) @(negedge clk);
    vbase = vcnt;
    en = 1'b0;
    repeat (100) @(negedge clk);
    checks++; if (vcnt != vbase) begin errors++; $display("FAIL en_no_valid got %0d pulses want 0", vcnt - vbase); end
    checks++; if (o_pass !== 2'b11 || o_all !== 1'b1 || o_lost !== 1'b0) begin
      errors++; $display("FAIL en_hold got pass %b all %b lost %b want 11 1 0", o_pass, o_all, o_lost); end
    en = 1'b1;
    wait_valid(200, cyc, ok);
    checks++; if (!ok || o_pass !== 2'b11) begin errors++; $display("FAIL en_resume got ok %b pass %b want 1 11", ok, o_pass); end
  endtask

  task automatic test_saturation();
    int cyc = 0; bit ok = 1'b0;
    while (!ok && cyc < 200) begin @(negedge clk); cyc++; ok = s_valid; end
    checks++; if (!ok) begin errors++; $display("FAIL sat_valid timeout"); end
    checks++; if (s_cnt !== 4'd15) begin errors++; $display("FAIL sat_cnt got %0d want 15", s_cnt); end
    checks++; if (s_pass !== 1'b1 || s_all !== 1'b1) begin errors++; $display("FAIL sat_pass got %b want 1", s_pass); end
  endtask

  task automatic test_reset_mid_gate();
    int cyc; bit ok;
    wait_valid(200, cyc, ok);
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (o_cnt !== 32'd0 || o_valid !== 1'b0 || o_pass !== 2'b00 || o_all !== 1'b0 || o_lost !== 1'b0) begin
      errors++; $display("FAIL rst_async got cnt %0h v %b pass %b all %b lost %b want all 0", o_cnt, o_valid, o_pass, o_all, o_lost); end
    checks++; if (s_cnt !== 4'd0) begin errors++; $display("FAIL rst_async_sat got %0d want 0", s_cnt); end
    exp_min = {16'd10, 16'd10};
    exp_max = {16'd5, 16'd5};
    @(negedge clk);
    rst_n = 1'b1;
    wait_valid(300, cyc, ok);
    checks++; if (!ok || o_pass !== 2'b00 || o_all !== 1'b0) begin
      errors++; $display("FAIL rst_minmax got ok %b pass %b all %b want 1 00 0", ok, o_pass, o_all); end
    checks++; if (o_cnt !== {16'd4, 16'd8}) begin errors++; $display("FAIL rst_cnt got %0h want 00040008", o_cnt); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_idle_channel();
    test_bounds();
    test_lock_lost();
    test_enable();
    test_saturation();
    test_reset_mid_gate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
